// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and one FIFO write port.
// The arbiter binds to the slave modport; producers/FIFO side bind to the master modport.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 2
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] din_bus;
  logic [NUM_REQ-1:0]            last;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic [IDX_W-1:0]              owner;
  logic                          locked;

  modport master (
    output req, din_bus, last, fifo_full,
    input  ack, fifo_wr_en, fifo_din, owner, locked
  );

  modport slave (
    input  req, din_bus, last, fifo_full,
    output ack, fifo_wr_en, fifo_din, owner, locked
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, zero-latency grant.
// Define FIFO_ARB_BURST_EN to enable burst locking (owner keeps the port until last[owner]).
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);

  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic [NUM_REQ-1:0]    ack_vec;
  logic [IDX_W-1:0]      ptr_reg;
  logic [IDX_W-1:0]      ptr_next;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_valid;
  logic                  transfer;
  logic                  locked_int;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign words[gi]   = bus.din_bus[gi*DATA_WIDTH +: DATA_WIDTH];
      assign ack_vec[gi] = transfer && (sel_idx == IDX_W'(gi));
    end
  endgenerate

  // Search starts just after the last winner and wraps, so the previous owner has lowest priority.
  always_comb begin
    logic [IDX_W-1:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!rr_found && bus.req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] lock_idx_reg;
  logic [IDX_W-1:0] lock_idx_next;

  // While locked, only the burst owner is eligible; everyone else waits.
  always_comb begin
    sel_idx   = rr_idx;
    sel_valid = rr_found;
    if (state_reg == LOCK) begin
      sel_idx   = lock_idx_reg;
      sel_valid = bus.req[lock_idx_reg];
    end
  end

  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    if (transfer) begin
      case (state_reg)
        IDLE: begin
          if (!bus.last[sel_idx]) begin
            state_next    = LOCK;
            lock_idx_next = sel_idx;
          end
        end
        LOCK: begin
          if (bus.last[sel_idx]) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lock_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

  assign locked_int = (state_reg == LOCK);
`else
  logic unused_last;

  assign sel_idx     = rr_idx;
  assign sel_valid   = rr_found;
  assign locked_int  = 1'b0;
  assign unused_last = ^bus.last;
`endif

  // Full or reset suppresses every grant, so no write can reach a full FIFO.
  assign transfer = rst && !bus.fifo_full && sel_valid;
  assign ptr_next = transfer ? sel_idx : ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign bus.ack        = ack_vec;
  assign bus.fifo_wr_en = transfer;
  assign bus.fifo_din   = transfer ? words[sel_idx] : '0;
  assign bus.owner      = rst ? ptr_reg : '0;
  assign bus.locked     = rst ? locked_int : 1'b0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin, full stall, wrap, FIFO end-to-end, burst.
// A small behavioural 16-deep FIFO and counting producers are used for the end-to-end case.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int IDX_W      = 2;
  localparam int DEPTH      = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic                          use_fifo = 1'b0;
  logic                          full_drv = 1'b0;
  logic [NUM_REQ*DATA_WIDTH-1:0] din_drv  = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] prod_bus;
  logic [3:0]                    prod_cnt [NUM_REQ];
  logic [DATA_WIDTH-1:0]         fifo_mem [DEPTH];
  int                            fifo_wp, fifo_rp, fifo_cnt;
  logic                          fifo_ovf;
  logic                          rd_en = 1'b0;
  logic                          wr_ok, rd_ok;

  assign bus.fifo_full = use_fifo ? (fifo_cnt == DEPTH) : full_drv;
  assign bus.din_bus   = use_fifo ? prod_bus : din_drv;
  assign wr_ok         = bus.fifo_wr_en && (fifo_cnt < DEPTH);
  assign rd_ok         = rd_en && (fifo_cnt > 0);

  // Producer i emits {i, n} where n counts its own acks.
  always_comb begin
    prod_bus = '0;
    for (int i = 0; i < NUM_REQ; i++)
      prod_bus[i*DATA_WIDTH +: DATA_WIDTH] = 8'((i << 4) + int'(prod_cnt[i]));
  end

  always @(posedge clk) begin
    if (!rst || !use_fifo) begin
      for (int i = 0; i < NUM_REQ; i++) prod_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.ack[i]) prod_cnt[i] <= prod_cnt[i] + 4'd1;
    end
  end

  always @(posedge clk) begin
    if (!rst || !use_fifo) begin
      fifo_wp  <= 0;
      fifo_rp  <= 0;
      fifo_cnt <= 0;
      fifo_ovf <= 1'b0;
    end else begin
      if (wr_ok) begin
        fifo_mem[fifo_wp] <= bus.fifo_din;
        fifo_wp           <= (fifo_wp + 1) % DEPTH;
      end
      if (bus.fifo_wr_en && !wr_ok) fifo_ovf <= 1'b1;
      if (rd_ok) fifo_rp <= (fifo_rp + 1) % DEPTH;
      fifo_cnt <= fifo_cnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req  = 4'b1111;
    bus.last = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) din_drv[i*DATA_WIDTH +: DATA_WIDTH] = 8'(8'hA0 + i);

    // T1: held in reset
    tick(); tick();
    check("t1_ack", 32'(bus.ack), 32'h0);
    check("t1_wr_en", 32'(bus.fifo_wr_en), 32'h0);
    check("t1_din", 32'(bus.fifo_din), 32'h0);
    check("t1_owner", 32'(bus.owner), 32'h0);
    check("t1_locked", 32'(bus.locked), 32'h0);

    // T2: all requesting -> A0..A3 twice
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_din%0d", i), 32'(bus.fifo_din), 32'(8'hA0 + (i % 4)));
      check($sformatf("t2_ack%0d", i), 32'(bus.ack), 32'(1 << (i % 4)));
      check($sformatf("t2_wr%0d", i), 32'(bus.fifo_wr_en), 32'h1);
      tick();
    end
    check("t2_owner", 32'(bus.owner), 32'h3);
    check("t2_locked", 32'(bus.locked), 32'h0);

    // T3: full stall then release
    bus.req  = 4'b0100;
    full_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t3_wr%0d", i), 32'(bus.fifo_wr_en), 32'h0);
      check($sformatf("t3_ack%0d", i), 32'(bus.ack), 32'h0);
      tick();
    end
    check("t3_owner_frozen", 32'(bus.owner), 32'h3);
    full_drv = 1'b0;
    #1;
    check("t3_ack_release", 32'(bus.ack), 32'h4);
    check("t3_din_release", 32'(bus.fifo_din), 32'hA2);
    tick();
    check("t3_owner", 32'(bus.owner), 32'h2);

    // T4: sparse wrap from ptr=3
    bus.req = 4'b1000;
    #1;
    check("t4_ack3", 32'(bus.ack), 32'h8);
    tick();
    check("t4_owner3", 32'(bus.owner), 32'h3);
    bus.req = 4'b0101;
    #1;
    check("t4_ack0", 32'(bus.ack), 32'h1);
    tick();
    check("t4_ack2", 32'(bus.ack), 32'h4);
    tick();
    check("t4_owner2", 32'(bus.owner), 32'h2);

    // idle: no requests
    bus.req = 4'b0000;
    #1;
    check("idle_ack", 32'(bus.ack), 32'h0);
    check("idle_wr", 32'(bus.fifo_wr_en), 32'h0);
    check("idle_din", 32'(bus.fifo_din), 32'h0);
    tick();
    check("idle_owner", 32'(bus.owner), 32'h2);

`ifndef FIFO_ARB_BURST_EN
    // last=0 must not lock when bursts are compiled out
    bus.req  = 4'b0010;
    bus.last = 4'b0000;
    #1;
    check("nb_ack1", 32'(bus.ack), 32'h2);
    tick();
    check("nb_locked", 32'(bus.locked), 32'h0);
    bus.req = 4'b0101;
    #1;
    check("nb_ack2", 32'(bus.ack), 32'h4);
    bus.last = 4'b1111;
`endif

    // T5: end-to-end with a 16-deep FIFO
    rst      = 1'b0;
    use_fifo = 1'b1;
    bus.req  = 4'b1111;
    tick();
    rst = 1'b1;
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("t5_wr%0d", k), 32'(bus.fifo_wr_en), 32'h1);
      check($sformatf("t5_din%0d", k), 32'(bus.fifo_din), 32'(8'(((k % 4) << 4) + k / 4)));
      tick();
    end
    check("t5_17th_ack", 32'(bus.ack), 32'h0);
    check("t5_17th_wr", 32'(bus.fifo_wr_en), 32'h0);
    tick();
    check("t5_still_blocked", 32'(bus.ack), 32'h0);
    bus.req = 4'b0000;
    rd_en   = 1'b1;
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("t5_rd%0d", k), 32'(fifo_mem[fifo_rp]), 32'(8'(((k % 4) << 4) + k / 4)));
      tick();
    end
    rd_en = 1'b0;
    check("t5_empty", 32'(fifo_cnt), 32'h0);
    check("t5_no_overflow", 32'(fifo_ovf), 32'h0);
    use_fifo = 1'b0;

`ifdef FIFO_ARB_BURST_EN
    // T6: burst from req1 with req0/req3 pending
    rst = 1'b0;
    tick();
    rst      = 1'b1;
    bus.req  = 4'b0001;
    bus.last = 4'b1111;
    #1;
    check("t6_pre_ack0", 32'(bus.ack), 32'h1);
    tick();
    bus.req  = 4'b1011;
    bus.last = 4'b0000;
    din_drv[8 +: 8] = 8'hB1;
    #1;
    check("t6_b1_ack", 32'(bus.ack), 32'h2);
    check("t6_b1_din", 32'(bus.fifo_din), 32'hB1);
    check("t6_b1_locked", 32'(bus.locked), 32'h0);
    tick();
    check("t6_lock_on", 32'(bus.locked), 32'h1);
    check("t6_owner1", 32'(bus.owner), 32'h1);
    din_drv[8 +: 8] = 8'hB2;
    #1;
    check("t6_b2_ack", 32'(bus.ack), 32'h2);
    check("t6_b2_din", 32'(bus.fifo_din), 32'hB2);
    tick();
    din_drv[8 +: 8] = 8'hB3;
    bus.last = 4'b0010;
    #1;
    check("t6_b3_ack", 32'(bus.ack), 32'h2);
    check("t6_b3_din", 32'(bus.fifo_din), 32'hB3);
    check("t6_b3_locked", 32'(bus.locked), 32'h1);
    tick();
    check("t6_unlock", 32'(bus.locked), 32'h0);
    bus.req  = 4'b1001;
    bus.last = 4'b0000;
    #1;
    check("t6_next_req3", 32'(bus.ack), 32'h8);
    tick();
    check("t6_lock3", 32'(bus.locked), 32'h1);
    check("t6_owner3", 32'(bus.owner), 32'h3);
    bus.req = 4'b0001;
    #1;
    check("t6_others_ignored", 32'(bus.ack), 32'h0);
    bus.req = 4'b1001;
    rst     = 1'b0;
    #1;
    check("t6_rst_ack", 32'(bus.ack), 32'h0);
    check("t6_rst_wr", 32'(bus.fifo_wr_en), 32'h0);
    tick();
    check("t6_rst_locked", 32'(bus.locked), 32'h0);
    check("t6_rst_owner", 32'(bus.owner), 32'h0);
    rst = 1'b1;
    #1;
    check("t6_after_rst_ack", 32'(bus.ack), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
